cache_l1_controller: RTL and testbench
======================================

// Module: cache_l1_controller
// PURPOSE
// - Per-CPU direct-mapped L1 with MSI coherence; sits directly upstream of the shared L2/directory.
// - Turns CPU loads/stores into hits or directory messages (read miss / invalidate / write miss) with victim write-back.
// - Services snoops forwarded by the directory from the peer CPU: supplies dirty data, aborts memory access.
// PARAMETERS
// - CPU_ID      0    CPU index, returned on dir_cpu_id
// - TAG_W       6    tag width; address = {tag, index}
// - IDX_W       2    index width; 2**IDX_W lines, one 8-bit word per line
// PORTS
// - clk            in   1   clock, rising edge
// - rst            in   1   reset, synchronous, active-high
// - cpu_req        in   1   CPU request valid; held until cpu_ready
// - cpu_we         in   1   1 = store, 0 = load
// - cpu_addr       in   8   CPU address
// - cpu_wdata      in   8   store data
// - cpu_ready      out  1   one-cycle pulse: request complete
// - cpu_rdata      out  8   load data, valid with cpu_ready
// - dir_msg        out  3   {read, invalidate, write} one-hot to directory, 000 = none
// - dir_addr       out  8   address of dir_msg / write-back / supplied block
// - dir_data       out  8   write-back or snoop-supply data
// - dir_wb         out  1   dir_data is a dirty write-back this cycle
// - dir_abort      out  1   this cache supplies data; memory access for dir_addr is aborted
// - dir_cpu_id     out  1   constant CPU_ID
// - reply_valid    in   1   fill data for the outstanding miss is valid
// - reply_data     in   8   fill data (memory or peer)
// - snoop_msg      in   3   {read, invalidate, write} from peer via directory
// - snoop_addr     in   8   snoop address
// BEHAVIOUR
// - Reset: all lines Invalid, tags/data 0; all outputs 0 except dir_cpu_id; FSM -> IDLE.
// - States: IDLE, LOOKUP, WRITEBACK, REQUEST, WAIT_REPLY, FILL.
// - IDLE: cpu_req=1 -> latch addr/we/wdata, go LOOKUP. Snoop on same index that cycle -> stay IDLE (snoop first).
// - LOOKUP hit: load on S/M, or store on M -> cpu_ready next cycle (hit latency 2 cycles from cpu_req), back to IDLE.
// - LOOKUP store on S (tag match) -> REQUEST with invalidate; no fill; on reply_valid line -> M, data=wdata, ready.
// - LOOKUP miss, victim M -> WRITEBACK: one cycle dir_wb=1, dir_addr=victim, dir_data=victim data; then REQUEST.
// - LOOKUP miss, victim I/S -> REQUEST directly (silent S eviction).
// - REQUEST: dir_msg = read (load) or write (store) for exactly one cycle, dir_addr=latched addr -> WAIT_REPLY.
// - WAIT_REPLY: hold until reply_valid; no timeout. FILL: write tag/data; state S (load) or M (store, data=wdata);
//   cpu_ready+cpu_rdata same cycle; -> IDLE.
// - Snoops evaluated every cycle, any state, same-cycle combinational response, update on clock edge:
//   - read hitting M: dir_data=line, dir_wb=1, dir_abort=1; line -> S.
//   - invalidate or write hitting S: line -> I; hitting M: supply as above, line -> I.
//   - miss or I: no response. Snoop output has priority over WRITEBACK output; WRITEBACK retries next cycle.
// - Snoop invalidating the line latched in LOOKUP: LOOKUP re-evaluates next cycle (treated as miss).
// - Snoop to the outstanding miss address during WAIT_REPLY: no action (line already I/not yet filled).
// - cpu_req dropped mid-operation: ignored; transaction completes, cpu_ready still pulses.
// - rst mid-operation: all lines Invalid, dirty data lost, FSM IDLE, no message emitted.
// CONFIGURATION
// - CACHE_L1_STATS_EN defined: adds outputs stat_hits[15:0], stat_misses[15:0]; count once per completed
//   request (LOOKUP hit / FILL), saturate at 16'hFFFF, clear on rst. Upgrade (S->M) counts as miss.
// - Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
// - Shared coherence_pkg: MSI encodings (I=2'b00, S=2'b01, M=2'b10), message bit positions
//   (READ=2, INV=1, WRITE=0), TAG_W/IDX_W defaults, FSM state enum.
// - One sub-module: l1_line_store (tag/state/data arrays; CPU port + snoop port, snoop write wins on same index).
// TESTING
// - Cold load 0x15 -> dir_msg=100 addr 0x15; reply 0xA5 -> cpu_rdata=0xA5, line 1 state S; reload hits in 2 cycles.
// - Store 0x15 while S -> dir_msg=010 one cycle, no fill read; reply_valid -> line M, data=wdata.
// - Line M (0x15, 0x3C), load 0x25 -> WRITEBACK dir_wb=1 addr 0x15 data 0x3C, then dir_msg=100 addr 0x25.
// - Line M 0x15, snoop read 0x15 -> same cycle dir_abort=1, dir_data=line, line -> S; snoop invalidate -> I.
// - cpu_req and snoop invalidate same index same cycle -> snoop applied first, request completes as a miss.
// - With CACHE_L1_STATS_EN: 3 hits + 2 misses -> stat_hits=3, stat_misses=2; rst -> both 0.

Source files
------------

// File: rtl/coherence_pkg.sv
// coherence_pkg
// Shared definitions for the L1 controller and the directory side:
//   - MSI line-state encodings
//   - bit positions of the one-hot {read, invalidate, write} message bus
//   - default tag/index widths
//   - the L1 controller FSM state enum
package coherence_pkg;

  localparam int DEF_TAG_W = 6;
  localparam int DEF_IDX_W = 2;

  localparam int MSG_READ  = 2;
  localparam int MSG_INV   = 1;
  localparam int MSG_WRITE = 0;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msiState_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REQUEST,
    WAIT_REPLY,
    FILL
  } ctrlState_t;

  // One-hot message vector with only the given bit set.
  function automatic logic [2:0] msgOneHot(input int bitPos);
    msgOneHot = 3'b001 << bitPos;
  endfunction

endpackage

// File: rtl/l1_line_store.sv
// l1_line_store
// Tag/state/data arrays for a direct-mapped L1, one 8-bit word per line.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (all lines I, tags/data 0)
//   cpuIdx                   CPU-side index; cpuTag/cpuState/cpuData read combinationally
//   cpuWe, cpuWr*            CPU-side write of tag, state and data at cpuIdx
//   snpIdx                   snoop-side index; snpTag/snpState/snpData read combinationally
//   snpWe, snpWrState        snoop-side state-only write at snpIdx
// When both ports write the same index in one cycle the snoop state wins;
// the CPU tag/data write still lands.
module l1_line_store
  import coherence_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] cpuIdx,
  output logic [TAG_W-1:0] cpuTag,
  output msiState_t        cpuState,
  output logic [7:0]       cpuData,
  input  logic             cpuWe,
  input  logic [TAG_W-1:0] cpuWrTag,
  input  msiState_t        cpuWrState,
  input  logic [7:0]       cpuWrData,
  input  logic [IDX_W-1:0] snpIdx,
  output logic [TAG_W-1:0] snpTag,
  output msiState_t        snpState,
  output logic [7:0]       snpData,
  input  logic             snpWe,
  input  msiState_t        snpWrState
);

  localparam int LINES = 1 << IDX_W;

  logic [TAG_W-1:0] tagMem   [LINES];
  msiState_t        stateMem [LINES];
  logic [7:0]       dataMem  [LINES];

  assign cpuTag   = tagMem[cpuIdx];
  assign cpuState = stateMem[cpuIdx];
  assign cpuData  = dataMem[cpuIdx];
  assign snpTag   = tagMem[snpIdx];
  assign snpState = stateMem[snpIdx];
  assign snpData  = dataMem[snpIdx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        tagMem[i]   <= '0;
        stateMem[i] <= MSI_I;
        dataMem[i]  <= '0;
      end
    end else begin
      if (cpuWe) begin
        tagMem[cpuIdx]  <= cpuWrTag;
        dataMem[cpuIdx] <= cpuWrData;
      end
      if (cpuWe && !(snpWe && (snpIdx == cpuIdx))) begin
        stateMem[cpuIdx] <= cpuWrState;
      end
      if (snpWe) begin
        stateMem[snpIdx] <= snpWrState;
      end
    end
  end

endmodule

// File: rtl/cache_l1_controller.sv
// cache_l1_controller
// Per-CPU direct-mapped L1 with MSI coherence, upstream of the shared L2/directory.
// CPU loads/stores become hits or directory messages (read / invalidate / write),
// with victim write-back. Peer snoops forwarded by the directory are answered in
// the same cycle (dirty data supplied, memory access aborted).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata     one-cycle completion pulse and load data
//   dir_msg                  {read, invalidate, write} one-hot to directory
//   dir_addr/data/wb/abort   message address, write-back/supply data and flags
//   dir_cpu_id               constant CPU_ID
//   reply_valid, reply_data  fill/ack for the outstanding miss
//   snoop_msg, snoop_addr    peer snoop via directory
// Optional build macro CACHE_L1_STATS_EN adds stat_hits/stat_misses (saturating).
//
// state      | meaning
// IDLE       | waiting for a CPU request (a same-index snoop is served first)
// LOOKUP     | tag/state check of the latched request
// WRITEBACK  | dirty victim pushed to the directory (one cycle, retried under snoop)
// REQUEST    | read / write / invalidate message for one cycle
// WAIT_REPLY | waiting for reply_valid, no timeout
// FILL       | write tag/state/data; cpu_ready pulses
module cache_l1_controller
  import coherence_pkg::*;
#(
  parameter int CPU_ID = 0,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic                   cpu_ready,
  output logic [7:0]             cpu_rdata,
  output logic [2:0]             dir_msg,
  output logic [TAG_W+IDX_W-1:0] dir_addr,
  output logic [7:0]             dir_data,
  output logic                   dir_wb,
  output logic                   dir_abort,
  output logic                   dir_cpu_id,
  input  logic                   reply_valid,
  input  logic [7:0]             reply_data,
`ifdef CACHE_L1_STATS_EN
  output logic [15:0]            stat_hits,
  output logic [15:0]            stat_misses,
`endif
  input  logic [2:0]             snoop_msg,
  input  logic [TAG_W+IDX_W-1:0] snoop_addr
);

  localparam int AW = TAG_W + IDX_W;

  ctrlState_t       state, nextState;
  logic [AW-1:0]    reqAddr;
  logic             reqWe;
  logic [7:0]       reqWdata;
  logic             isUpgrade;
  logic [7:0]       fillData;
  logic             cpuReadyQ;
  logic [7:0]       rdataQ;

  logic [TAG_W-1:0] reqTag, snpTagIn;
  logic [IDX_W-1:0] reqIdx, snpIdxIn;
  logic [TAG_W-1:0] lineTag, snpLineTag;
  msiState_t        lineState, snpLineState;
  logic [7:0]       lineData, snpLineData;

  logic             cpuWe;
  logic [TAG_W-1:0] cpuWrTag;
  msiState_t        cpuWrState;
  logic [7:0]       cpuWrData;

  logic             snpAny, snpKill, snpHit, snpSupply, snpWe;
  msiState_t        snpWrState;

  logic             lineHit, latchReq, hitDone, fillArm, wbFire;
  logic [2:0]       dirMsg;

  assign reqTag   = reqAddr[AW-1:IDX_W];
  assign reqIdx   = reqAddr[IDX_W-1:0];
  assign snpTagIn = snoop_addr[AW-1:IDX_W];
  assign snpIdxIn = snoop_addr[IDX_W-1:0];

  l1_line_store #(
    .TAG_W(TAG_W),
    .IDX_W(IDX_W)
  ) uStore (
    .clk       (clk),
    .rst       (rst),
    .cpuIdx    (reqIdx),
    .cpuTag    (lineTag),
    .cpuState  (lineState),
    .cpuData   (lineData),
    .cpuWe     (cpuWe),
    .cpuWrTag  (cpuWrTag),
    .cpuWrState(cpuWrState),
    .cpuWrData (cpuWrData),
    .snpIdx    (snpIdxIn),
    .snpTag    (snpLineTag),
    .snpState  (snpLineState),
    .snpData   (snpLineData),
    .snpWe     (snpWe),
    .snpWrState(snpWrState)
  );

  // Snoop path: any state, combinational response, state change on the edge.
  // A read hitting S needs no change; everything else that hits updates the line.
  assign snpAny     = |snoop_msg;
  assign snpKill    = snoop_msg[MSG_INV] | snoop_msg[MSG_WRITE];
  assign snpHit     = snpAny && (snpLineState != MSI_I) && (snpLineTag == snpTagIn);
  assign snpSupply  = snpHit && (snpLineState == MSI_M);
  assign snpWe      = snpHit && (snpKill || (snpLineState == MSI_M));
  assign snpWrState = snpKill ? MSI_I : MSI_S;

  assign lineHit = (lineState != MSI_I) && (lineTag == reqTag);
  assign fillArm = (state == WAIT_REPLY) && reply_valid;

  always_comb begin
    nextState  = state;
    latchReq   = 1'b0;
    hitDone    = 1'b0;
    wbFire     = 1'b0;
    dirMsg     = 3'b000;
    cpuWe      = 1'b0;
    cpuWrTag   = lineTag;
    cpuWrState = lineState;
    cpuWrData  = lineData;
    case (state)
      IDLE: begin
        // cpuReadyQ high means the CPU has not yet dropped the finished request.
        if (cpu_req && !cpuReadyQ) begin
          if (!(snpAny && (snpIdxIn == cpu_addr[IDX_W-1:0]))) begin
            latchReq  = 1'b1;
            nextState = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (snpWe && (snpIdxIn == reqIdx)) begin
          nextState = LOOKUP;
        end else if (lineHit && (!reqWe || (lineState == MSI_M))) begin
          hitDone   = 1'b1;
          nextState = IDLE;
          if (reqWe) begin
            cpuWe     = 1'b1;
            cpuWrData = reqWdata;
          end
        end else if (lineHit) begin
          nextState = REQUEST;
        end else if (lineState == MSI_M) begin
          nextState = WRITEBACK;
        end else begin
          nextState = REQUEST;
        end
      end
      WRITEBACK: begin
        if (!snpSupply) begin
          // A snoop may already have taken the victim out of M; then nothing to push.
          if (lineState == MSI_M) begin
            wbFire     = 1'b1;
            cpuWe      = 1'b1;
            cpuWrState = MSI_I;
          end
          nextState = REQUEST;
        end
      end
      REQUEST: begin
        if (!snpSupply) begin
          if (isUpgrade)  dirMsg = msgOneHot(MSG_INV);
          else if (reqWe) dirMsg = msgOneHot(MSG_WRITE);
          else            dirMsg = msgOneHot(MSG_READ);
          nextState = WAIT_REPLY;
        end
      end
      WAIT_REPLY: begin
        if (reply_valid) nextState = FILL;
      end
      FILL: begin
        cpuWe      = 1'b1;
        cpuWrTag   = reqTag;
        cpuWrState = reqWe ? MSI_M : MSI_S;
        cpuWrData  = reqWe ? reqWdata : fillData;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      reqAddr   <= '0;
      reqWe     <= 1'b0;
      reqWdata  <= '0;
      isUpgrade <= 1'b0;
      fillData  <= '0;
      cpuReadyQ <= 1'b0;
      rdataQ    <= '0;
    end else begin
      state     <= nextState;
      cpuReadyQ <= hitDone | fillArm;
      if (latchReq) begin
        reqAddr  <= cpu_addr;
        reqWe    <= cpu_we;
        reqWdata <= cpu_wdata;
      end
      if (state == LOOKUP) isUpgrade <= lineHit;
      if (fillArm) fillData <= reply_data;
      if (hitDone)      rdataQ <= reqWe ? reqWdata : lineData;
      else if (fillArm) rdataQ <= reqWe ? reqWdata : reply_data;
    end
  end

  assign cpu_ready  = cpuReadyQ;
  assign cpu_rdata  = rdataQ;
  assign dir_msg    = dirMsg;
  assign dir_wb     = snpSupply | wbFire;
  assign dir_abort  = snpSupply;
  assign dir_data   = snpSupply ? snpLineData : (wbFire ? lineData : 8'h00);
  assign dir_addr   = snpSupply ? snoop_addr :
                      wbFire ? {lineTag, reqIdx} :
                      (dirMsg != 3'b000) ? reqAddr : '0;
  assign dir_cpu_id = 1'(CPU_ID);

`ifdef CACHE_L1_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hitDone && (stat_hits != 16'hFFFF)) stat_hits <= stat_hits + 16'd1;
      if ((state == FILL) && (stat_misses != 16'hFFFF)) stat_misses <= stat_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_l1_controller.sv
// tb_cache_l1_controller
// Directed bench for cache_l1_controller. Inputs change 1 time unit after the
// rising edge; outputs are sampled after that, away from the edge.
// With CACHE_L1_STATS_EN defined the statistics ports are also connected and checked.
module tb_cache_l1_controller;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_ready;
  logic [7:0] cpu_rdata;
  logic [2:0] dir_msg;
  logic [7:0] dir_addr, dir_data;
  logic       dir_wb, dir_abort, dir_cpu_id;
  logic       reply_valid;
  logic [7:0] reply_data;
  logic [2:0] snoop_msg;
  logic [7:0] snoop_addr;
`ifdef CACHE_L1_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  int nChecks = 0;
  int nFails  = 0;

  cache_l1_controller #(.CPU_ID(0), .TAG_W(6), .IDX_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .dir_msg    (dir_msg),
    .dir_addr   (dir_addr),
    .dir_data   (dir_data),
    .dir_wb     (dir_wb),
    .dir_abort  (dir_abort),
    .dir_cpu_id (dir_cpu_id),
    .reply_valid(reply_valid),
    .reply_data (reply_data),
`ifdef CACHE_L1_STATS_EN
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
`endif
    .snoop_msg  (snoop_msg),
    .snoop_addr (snoop_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    reply_valid = 1'b0; reply_data = '0; snoop_msg = '0; snoop_addr = '0;
    tick(); tick();
    chk("rst_ready",  16'(cpu_ready), 16'd0);
    chk("rst_rdata",  16'(cpu_rdata), 16'd0);
    chk("rst_msg",    16'(dir_msg),   16'd0);
    chk("rst_addr",   16'(dir_addr),  16'd0);
    chk("rst_data",   16'(dir_data),  16'd0);
    chk("rst_wb",     16'(dir_wb),    16'd0);
    chk("rst_abort",  16'(dir_abort), 16'd0);
    chk("rst_cpu_id", 16'(dir_cpu_id), 16'd0);
    rst = 1'b0;

    // Cold load 0x15 -> read miss, fill 0xA5
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h15;
    tick();
    chk("cold_lookup_ready", 16'(cpu_ready), 16'd0);
    tick();
    chk("cold_req_msg",  16'(dir_msg),  16'h4);
    chk("cold_req_addr", 16'(dir_addr), 16'h15);
    tick();
    chk("cold_wait_msg", 16'(dir_msg), 16'd0);
    tick();
    reply_valid = 1'b1; reply_data = 8'hA5;
    tick();
    reply_valid = 1'b0;
    chk("cold_fill_ready", 16'(cpu_ready), 16'd1);
    chk("cold_fill_rdata", 16'(cpu_rdata), 16'hA5);
    cpu_req = 1'b0;
    tick();
    chk("cold_ready_pulse", 16'(cpu_ready), 16'd0);
    // Line is S: snoop read gets no response
    snoop_msg = 3'b100; snoop_addr = 8'h15; #1;
    chk("s_snoop_abort", 16'(dir_abort), 16'd0);
    chk("s_snoop_wb",    16'(dir_wb),    16'd0);
    tick();
    snoop_msg = 3'b000;

    // Reload hit: ready two edges after request
    cpu_req = 1'b1; cpu_addr = 8'h15;
    tick();
    chk("hit_ready_early", 16'(cpu_ready), 16'd0);
    tick();
    chk("hit_ready", 16'(cpu_ready), 16'd1);
    chk("hit_rdata", 16'(cpu_rdata), 16'hA5);
    chk("hit_msg",   16'(dir_msg),   16'd0);
    cpu_req = 1'b0;
    tick();

    // Store 0x15 while S -> invalidate upgrade, line M 0x3C
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h15; cpu_wdata = 8'h3C;
    tick(); tick();
    chk("upg_msg",  16'(dir_msg),  16'h2);
    chk("upg_addr", 16'(dir_addr), 16'h15);
    tick();
    chk("upg_wait_msg", 16'(dir_msg), 16'd0);
    reply_valid = 1'b1; reply_data = 8'h00;
    tick();
    reply_valid = 1'b0;
    chk("upg_ready", 16'(cpu_ready), 16'd1);
    chk("upg_rdata", 16'(cpu_rdata), 16'h3C);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Load 0x25 conflicts with dirty 0x15 -> write-back then read
    cpu_req = 1'b1; cpu_addr = 8'h25;
    tick(); tick();
    chk("wb_flag", 16'(dir_wb),   16'd1);
    chk("wb_addr", 16'(dir_addr), 16'h15);
    chk("wb_data", 16'(dir_data), 16'h3C);
    chk("wb_msg",  16'(dir_msg),  16'd0);
    tick();
    chk("wb_req_msg",  16'(dir_msg),  16'h4);
    chk("wb_req_addr", 16'(dir_addr), 16'h25);
    chk("wb_req_wb",   16'(dir_wb),   16'd0);
    tick();
    reply_valid = 1'b1; reply_data = 8'h77;
    tick();
    reply_valid = 1'b0;
    chk("wb_fill_rdata", 16'(cpu_rdata), 16'h77);
    cpu_req = 1'b0;
    tick();

    // Store miss 0x15 over clean 0x25 -> write message, no write-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h15; cpu_wdata = 8'h3C;
    tick(); tick();
    chk("stmiss_msg",  16'(dir_msg),  16'h1);
    chk("stmiss_addr", 16'(dir_addr), 16'h15);
    chk("stmiss_wb",   16'(dir_wb),   16'd0);
    tick();
    reply_valid = 1'b1; reply_data = 8'h11;
    tick();
    reply_valid = 1'b0;
    chk("stmiss_ready", 16'(cpu_ready), 16'd1);
    chk("stmiss_rdata", 16'(cpu_rdata), 16'h3C);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Snoop read hitting M: same-cycle supply, line -> S
    snoop_msg = 3'b100; snoop_addr = 8'h15; #1;
    chk("snp_m_abort", 16'(dir_abort), 16'd1);
    chk("snp_m_wb",    16'(dir_wb),    16'd1);
    chk("snp_m_data",  16'(dir_data),  16'h3C);
    chk("snp_m_addr",  16'(dir_addr),  16'h15);
    tick();
    chk("snp_s_abort", 16'(dir_abort), 16'd0);
    snoop_msg = 3'b010; #1;
    chk("snp_inv_s_abort", 16'(dir_abort), 16'd0);
    tick();
    snoop_msg = 3'b000;
    // Line now I: load misses
    cpu_req = 1'b1; cpu_addr = 8'h15;
    tick(); tick();
    chk("after_inv_msg", 16'(dir_msg), 16'h4);
    tick();
    reply_valid = 1'b1; reply_data = 8'h42;
    tick();
    reply_valid = 1'b0;
    chk("after_inv_rdata", 16'(cpu_rdata), 16'h42);
    cpu_req = 1'b0;
    tick();

    // Request and invalidate on the same index in the same cycle: snoop first
    cpu_req = 1'b1; cpu_addr = 8'h15; snoop_msg = 3'b010; snoop_addr = 8'h15;
    tick();
    snoop_msg = 3'b000;
    chk("sf_idle_ready", 16'(cpu_ready), 16'd0);
    tick();
    chk("sf_lookup_msg", 16'(dir_msg), 16'd0);
    tick();
    chk("sf_req_msg",  16'(dir_msg),  16'h4);
    chk("sf_req_addr", 16'(dir_addr), 16'h15);
    tick();
    reply_valid = 1'b1; reply_data = 8'h5A;
    tick();
    reply_valid = 1'b0;
    chk("sf_ready", 16'(cpu_ready), 16'd1);
    chk("sf_rdata", 16'(cpu_rdata), 16'h5A);
    cpu_req = 1'b0;
    tick();
`ifdef CACHE_L1_STATS_EN
    chk("stat_hits",   stat_hits,   16'd1);
    chk("stat_misses", stat_misses, 16'd6);
`endif

    // Reset in the middle of a miss
    cpu_req = 1'b1; cpu_addr = 8'h25;
    tick(); tick();
    chk("rmid_req_msg", 16'(dir_msg), 16'h4);
    rst = 1'b1;
    tick();
    chk("rmid_msg",   16'(dir_msg),   16'd0);
    chk("rmid_ready", 16'(cpu_ready), 16'd0);
`ifdef CACHE_L1_STATS_EN
    chk("rmid_stat_hits",   stat_hits,   16'd0);
    chk("rmid_stat_misses", stat_misses, 16'd0);
`endif
    rst = 1'b0; cpu_req = 1'b0;
    tick();
    // Previously valid 0x15 is gone after reset
    cpu_req = 1'b1; cpu_addr = 8'h15;
    tick(); tick();
    chk("post_rst_msg",   16'(dir_msg),   16'h4);
    chk("post_rst_ready", 16'(cpu_ready), 16'd0);
    cpu_req = 1'b0;
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
